fifo_pkt_reader: RTL and testbench

- Read-side consumer for the team's dual-clock FWFT FIFO, running entirely in the FIFO read clock domain.
- Pops framed words (sop/eop flags stored above the payload), validates framing and length, and drives a one-beat-per-cycle valid/ready stream into the switch core.
- Malformed framing is repaired so downstream always sees balanced sop/eop: orphan words are dropped, packets are terminated with an error flag, and oversize packets are flushed.

---
 rtl/fifo_pkt_pkg.sv | 22 ++
 rtl/sat_counter.sv | 21 ++
 rtl/fifo_pkt_reader.sv | 169 ++++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkt_pkg.sv
// Shared types and constants for the FIFO packet reader: FSM states, framing bit
// positions within a FIFO word, and the default maximum packet length.
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_LEN = 2048;

    // The framing flags sit directly above the payload: {sop, eop, data}.
    function automatic int SOP_BIT(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int EOP_BIT(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Read-side consumer of the FWFT packet FIFO: pops framed words, repairs broken
// framing and drives a one-beat-per-cycle valid/ready stream with length/error tags.
module fifo_pkt_reader
    import fifo_pkt_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = 12,
    parameter int CNT_W   = 16
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic              m_err,
    output logic [LEN_W-1:0]  m_len,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  orphan_cnt
);

    localparam int SOP_IDX = SOP_BIT(DATA_W);
    localparam int EOP_IDX = EOP_BIT(DATA_W);

    state_t            state, state_next;
    logic [LEN_W-1:0]  len, len_inc;
    logic              head_sop, head_eop;
    logic [DATA_W-1:0] head_data;
    logic              can_load, pop, load, orphan_inc, accept_eop;
    logic [DATA_W-1:0] ld_data;
    logic              ld_sop, ld_eop, ld_err;
    logic [LEN_W-1:0]  ld_len;

    assign head_sop  = fifo_dout[SOP_IDX];
    assign head_eop  = fifo_dout[EOP_IDX];
    assign head_data = fifo_dout[DATA_W-1:0];
    assign can_load  = ~fifo_empty & (~m_valid | m_ready);
    assign len_inc   = len + LEN_W'(1);

    // NOTE: every signal driven here gets a default first, so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        orphan_inc = 1'b0;
        ld_data    = head_data;
        ld_sop     = 1'b0;
        ld_eop     = 1'b0;
        ld_err     = 1'b0;
        ld_len     = len_inc;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_sop) begin
                        if (can_load) begin
                            pop    = 1'b1;
                            load   = 1'b1;
                            ld_sop = 1'b1;
                            ld_eop = head_eop;
                            ld_len = LEN_W'(1);
                            if (!head_eop) state_next = XFER;
                        end
                    end else begin
                        // Orphans are dropped even while the output is stalled.
                        pop        = 1'b1;
                        orphan_inc = 1'b1;
                    end
                end
            end
            XFER: begin
                if (can_load) begin
                    load = 1'b1;
                    if (head_sop) begin
                        // Missing eop: close the open packet, leave the sop word queued.
                        ld_data    = '0;
                        ld_eop     = 1'b1;
                        ld_err     = 1'b1;
                        ld_len     = len;
                        state_next = IDLE;
                    end else begin
                        pop = 1'b1;
                        if (head_eop) begin
                            ld_eop     = 1'b1;
                            state_next = IDLE;
                        end else if (len_inc == LEN_W'(MAX_LEN)) begin
                            ld_eop     = 1'b1;
                            ld_err     = 1'b1;
                            state_next = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (!fifo_empty) begin
                    if (head_sop) begin
                        state_next = IDLE;
                    end else begin
                        pop = 1'b1;
                        if (head_eop) state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fifo_rd_en = pop & rst_n;

    always_ff @(posedge rd_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the length tracker is reset along with the visible outputs so a packet
    // abandoned by reset cannot leak its count into the next one.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
            m_err   <= 1'b0;
            m_len   <= '0;
            len     <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= ld_data;
            m_sop   <= ld_sop;
            m_eop   <= ld_eop;
            m_err   <= ld_err;
            m_len   <= ld_len;
            len     <= ld_len;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    assign accept_eop = m_valid & m_ready & m_eop;

    sat_counter #(.WIDTH(CNT_W)) u_pkt_cnt (
        .clk   (rd_clk),
        .clr_n (rst_n),
        .inc   (accept_eop & ~m_err),
        .count (pkt_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (rd_clk),
        .clr_n (rst_n),
        .inc   (accept_eop & m_err),
        .count (err_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_orphan_cnt (
        .clk   (rd_clk),
        .clr_n (rst_n),
        .inc   (orphan_inc),
        .count (orphan_cnt)
    );

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench: a FWFT FIFO model feeds the reader; a stream-level packet
// model predicts every accepted beat and the statistics counters.
module tb_fifo_pkt_reader;

    localparam int DATA_W  = 32;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 12;
    localparam int CNT_W   = 16;
    localparam int FW      = DATA_W + 2;
    localparam int DEPTH   = 4096;

    logic              rd_clk = 1'b0;
    logic              rst_n  = 1'b0;
    logic [FW-1:0]     fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_sop, m_eop, m_err;
    logic [LEN_W-1:0]  m_len;
    logic [CNT_W-1:0]  pkt_cnt, err_cnt, orphan_cnt;

    fifo_pkt_reader #(
        .DATA_W (DATA_W),
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .rd_clk     (rd_clk),
        .rst_n      (rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .m_err      (m_err),
        .m_len      (m_len),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt),
        .orphan_cnt (orphan_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // FWFT FIFO model
    logic [FW-1:0] mem [DEPTH];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr % DEPTH];
    always @(posedge rd_clk) if (fifo_rd_en) rd_ptr <= rd_ptr + 1;

    int vectors = 0;
    int miscompares = 0;

    // Stream-level reference model
    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sop, eop, err;
        logic [LEN_W-1:0]  len;
    } beat_t;

    beat_t exp_q[$];
    int    exp_pkt = 0, exp_err = 0, exp_orph = 0;
    bit    in_pkt = 0, flushing = 0;
    int    cur_len = 0;

    function automatic void emit(logic [DATA_W-1:0] d, bit s, bit e, bit r, int l);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e; b.err = r; b.len = LEN_W'(l);
        exp_q.push_back(b);
        if (e) begin
            if (r) exp_err++;
            else   exp_pkt++;
        end
    endfunction

    task automatic model_word(bit sop, bit eop, logic [DATA_W-1:0] d);
        if (flushing) begin
            if (!sop) begin
                if (eop) flushing = 0;
                return;
            end
            flushing = 0;
        end
        if (in_pkt && sop) begin
            emit('0, 0, 1, 1, cur_len);
            in_pkt = 0;
        end
        if (!in_pkt) begin
            if (sop) begin
                cur_len = 1;
                emit(d, 1, eop, 0, 1);
                in_pkt = !eop;
            end else begin
                exp_orph++;
            end
        end else begin
            cur_len++;
            if (eop) begin
                emit(d, 0, 1, 0, cur_len);
                in_pkt = 0;
            end else if (cur_len == MAX_LEN) begin
                emit(d, 0, 1, 1, MAX_LEN);
                in_pkt   = 0;
                flushing = 1;
            end else begin
                emit(d, 0, 0, 0, cur_len);
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pkt = 0; exp_err = 0; exp_orph = 0;
        in_pkt = 0; flushing = 0; cur_len = 0;
    endtask

    task automatic push_word(bit sop, bit eop, logic [DATA_W-1:0] d);
        mem[wr_ptr % DEPTH] = {sop, eop, d};
        wr_ptr++;
        model_word(sop, eop, d);
    endtask

    task automatic push_pkt(int n);
        for (int i = 0; i < n; i++) push_word(i == 0, i == n - 1, $urandom);
    endtask

    // Downstream ready driver: 0 = always ready, 1 = toggle 1,0,1,0..., 2 = random
    int ready_mode = 0;
    initial forever begin
        @(posedge rd_clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = ($urandom_range(0, 99) < 60);
        endcase
    end

    // Scoreboard and protocol monitor, sampled on the falling edge
    int    cyc = 0;
    int    acc_cyc[$];
    bit    prev_stall = 0;
    bit    chk_stall_pop = 0;
    beat_t prev;

    always @(negedge rd_clk) begin
        beat_t e;
        cyc++;
        if (fifo_empty) begin
            vectors++;
            if (fifo_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL rd_en_while_empty: got %b expected 0", fifo_rd_en);
            end
        end
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== prev.data || m_sop !== prev.sop ||
                    m_eop !== prev.eop || m_err !== prev.err || m_len !== prev.len) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b d=%h s=%b e=%b expected v=1 d=%h s=%b e=%b",
                             m_valid, m_data, m_sop, m_eop, prev.data, prev.sop, prev.eop);
                end
            end
            if (chk_stall_pop && m_valid && !m_ready) begin
                vectors++;
                if (fifo_rd_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pop_on_stall: got %b expected 0", fifo_rd_en);
                end
            end
            if (m_valid && m_ready) begin
                acc_cyc.push_back(cyc);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got d=%h sop=%b eop=%b expected no beat",
                             m_data, m_sop, m_eop);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.data || m_sop !== e.sop || m_eop !== e.eop ||
                        (e.eop && (m_err !== e.err || m_len !== e.len))) begin
                        miscompares++;
                        $display("FAIL beat: got d=%h sop=%b eop=%b err=%b len=%0d expected d=%h sop=%b eop=%b err=%b len=%0d",
                                 m_data, m_sop, m_eop, m_err, m_len, e.data, e.sop, e.eop, e.err, e.len);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev.data = m_data; prev.sop = m_sop; prev.eop = m_eop;
            prev.err  = m_err;  prev.len = m_len;
        end
    end

    task automatic drain(string name);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge rd_clk);
            #1;
            done = (exp_q.size() == 0) && fifo_empty && !m_valid;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_drain_timeout: got %0d beats pending expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_counters(string name);
        vectors++;
        if (pkt_cnt !== CNT_W'(exp_pkt)) begin
            miscompares++;
            $display("FAIL %s_pkt_cnt: got %0d expected %0d", name, pkt_cnt, exp_pkt);
        end
        vectors++;
        if (err_cnt !== CNT_W'(exp_err)) begin
            miscompares++;
            $display("FAIL %s_err_cnt: got %0d expected %0d", name, err_cnt, exp_err);
        end
        vectors++;
        if (orphan_cnt !== CNT_W'(exp_orph)) begin
            miscompares++;
            $display("FAIL %s_orphan_cnt: got %0d expected %0d", name, orphan_cnt, exp_orph);
        end
    endtask

    task automatic check_outputs_zero(string name);
        logic [DATA_W+LEN_W+3*CNT_W+3:0] obs;
        obs = {m_valid, m_data, m_sop, m_eop, m_err, m_len, pkt_cnt, err_cnt, orphan_cnt};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL %s_outputs: got %h expected 0", name, obs);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        check_outputs_zero("reset");
        @(posedge rd_clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        ready_mode = 0;
        @(posedge rd_clk);
        #1;
        acc_cyc.delete();
        push_pkt(1);
        push_pkt(3);
        push_pkt(5);
        drain("b2b");
        vectors++;
        if (acc_cyc.size() != 9) begin
            miscompares++;
            $display("FAIL b2b_beats: got %0d expected 9", acc_cyc.size());
        end else begin
            vectors++;
            if (acc_cyc[8] - acc_cyc[0] != 8) begin
                miscompares++;
                $display("FAIL b2b_span: got %0d cycles expected 8", acc_cyc[8] - acc_cyc[0]);
            end
        end
        check_counters("b2b");
    endtask

    task automatic test_stall_toggle();
        ready_mode = 1;
        chk_stall_pop = 1;
        @(posedge rd_clk);
        #1;
        acc_cyc.delete();
        push_pkt(4);
        drain("stall");
        chk_stall_pop = 0;
        vectors++;
        if (acc_cyc.size() != 4) begin
            miscompares++;
            $display("FAIL stall_beats: got %0d expected 4", acc_cyc.size());
        end
        check_counters("stall");
        ready_mode = 0;
    endtask

    task automatic test_orphans();
        @(posedge rd_clk);
        #1;
        push_word(0, 0, $urandom);
        push_word(0, 0, $urandom);
        push_pkt(2);
        drain("orphan");
        check_counters("orphan");
    endtask

    task automatic test_missing_eop();
        @(posedge rd_clk);
        #1;
        push_word(1, 0, $urandom);
        push_word(0, 0, $urandom);
        push_word(0, 0, $urandom);
        push_pkt(3);
        drain("missing_eop");
        check_counters("missing_eop");
    endtask

    task automatic test_oversize();
        @(posedge rd_clk);
        #1;
        push_pkt(MAX_LEN + 3);
        push_pkt(2);
        drain("oversize");
        check_counters("oversize");
    endtask

    task automatic test_reset_mid_packet();
        ready_mode = 0;
        @(posedge rd_clk);
        #1;
        push_word(1, 0, $urandom);
        push_word(0, 0, $urandom);
        push_word(0, 0, $urandom);
        drain("mid_reset_pre");
        @(posedge rd_clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        push_word(0, 0, $urandom);
        push_word(0, 0, $urandom);
        push_word(0, 1, $urandom);
        @(negedge rd_clk);
        vectors++;
        if (fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_rd_en: got %b expected 0", fifo_rd_en);
        end
        @(posedge rd_clk);
        #1;
        rst_n = 1'b1;
        @(negedge rd_clk);
        check_outputs_zero("mid_reset");
        drain("mid_reset_post");
        check_counters("mid_reset_orphans");
        @(posedge rd_clk);
        #1;
        push_pkt(2);
        drain("mid_reset_pkt");
        check_counters("mid_reset_pkt");
    endtask

    task automatic test_random();
        int kind, n, gap;
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            @(posedge rd_clk);
            #1;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                push_word(0, 1'($urandom_range(0, 1)), $urandom);
            end else begin
                n = $urandom_range(1, MAX_LEN + 3);
                for (int i = 0; i < n; i++)
                    push_word(i == 0, (kind != 1) && (i == n - 1), $urandom);
            end
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge rd_clk);
        end
        @(posedge rd_clk);
        #1;
        push_pkt(3);
        drain("random");
        check_counters("random");
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_toggle();
        test_orphans();
        test_missing_eop();
        test_oversize();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
